// File: rtl/eng_controller.sv
// Moore sequencer for the exponential-engine datapath: steps the term/result
// registers through x^k/k! accumulation and stops on counter carry or watchdog.
module eng_controller #(
   parameter int unsigned MAX_ITER = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic co,
   output logic zx,
   output logic initx,
   output logic ldx,
   output logic zt,
   output logic initt,
   output logic ldt,
   output logic zr,
   output logic initr,
   output logic ldr,
   output logic zc,
   output logic ldc,
   output logic enc,
   output logic s,
   output logic busy,
   output logic done,
   output logic err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MULX,
      S_MULC,
      S_ACC,
      S_DONE,
      S_ERR,
      S_WAIT
   } state_t;

   localparam logic [3:0] ITER_LIMIT = 4'(MAX_ITER);

   state_t     state_q, state_d;
   logic [3:0] it_q, it_d;
   logic       err_q, err_d;
   logic [3:0] it_inc;

   assign it_inc = it_q + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         it_q    <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         it_q    <= it_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      it_d    = it_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_LOAD;
         S_LOAD: begin
            it_d    = 4'd0;
            err_d   = 1'b0;
            state_d = S_MULX;
         end
         S_MULX: state_d = S_MULC;
         S_MULC: state_d = S_ACC;
         // carry takes priority over the watchdog when both land on the same ACC
         S_ACC: begin
            it_d = it_inc;
            if (co)                        state_d = S_DONE;
            else if (it_inc == ITER_LIMIT) state_d = S_ERR;
            else                           state_d = S_MULX;
         end
         S_DONE: state_d = S_WAIT;
         S_ERR: begin
            err_d   = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: if (!start) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      zx    = 1'b0;
      initx = 1'b0;
      ldx   = 1'b0;
      zt    = 1'b0;
      initt = 1'b0;
      ldt   = 1'b0;
      zr    = 1'b0;
      initr = 1'b0;
      ldr   = 1'b0;
      zc    = 1'b0;
      ldc   = 1'b0;
      enc   = 1'b0;
      s     = 1'b0;
      done  = 1'b0;
      busy  = (state_q != S_IDLE) && (state_q != S_WAIT);
      case (state_q)
         S_LOAD: begin
            ldx   = 1'b1;
            initt = 1'b1;
            initr = 1'b1;
            zc    = 1'b1;
         end
         S_MULX: ldt = 1'b1;
         S_MULC: begin
            s   = 1'b1;
            ldt = 1'b1;
         end
         S_ACC: begin
            ldr = 1'b1;
            enc = 1'b1;
         end
         S_DONE,
         S_ERR:  done = 1'b1;
         default: ;
      endcase
   end

   assign err = err_q;

endmodule
